truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
Controller that exhaustively sequences a small combinational datapath (3 inputs, 2 outputs in the course exercises) through every input combination. It holds each vector for a programmable settle time, samples the outputs, and packs them into a truth-table register. It compares that table against an expected table and reports pass/fail. It sits between a top-level start/done handshake and the combinational unit under exercise, replacing hand-written stimulus sequences.

Parameters:
N_IN, 3, number of datapath inputs; the sweep covers 2**N_IN vectors (legal 1..6)
N_OUT, 2, number of datapath outputs sampled per vector (legal 1..4)
HOLD_CYCLES, 4, settle cycles each vector is held before sampling (legal >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a sweep; accepted only in IDLE
exp_table  input  (2**N_IN)*N_OUT  expected outputs, vector i at bits [i*N_OUT +: N_OUT]; latched at start accept
dut_in  output  N_IN  vector driven to the datapath (registered)
dut_out  input  N_OUT  datapath outputs, sampled in SAMPLE
busy  output  1  high in SETTLE and SAMPLE
done  output  1  one-cycle pulse in FINISH
pass  output  1  1 when last sweep had zero mismatches; held until next start
table_out  output  (2**N_IN)*N_OUT  captured outputs, same packing as exp_table
mismatch_cnt  output  N_IN+1  number of mismatching vectors in last sweep
first_fail_idx  output  N_IN  lowest mismatching vector index; meaningful only when mismatch_cnt != 0

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE. dut_in, busy, done, pass, table_out, mismatch_cnt, first_fail_idx and internal idx/cnt all = 0. Reset overrides every other input, including mid-sweep; the partial sweep is discarded.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE: on start=1: exp latch<=exp_table; idx<=0; dut_in<=0; cnt<=HOLD_CYCLES-1; table_out, mismatch_cnt, first_fail_idx, pass <= 0; go to SETTLE. With start=0, all results hold.
- SETTLE: if cnt==0 go to SAMPLE, else cnt<=cnt-1. Occupies exactly HOLD_CYCLES cycles.
- SAMPLE (1 cycle): table_out[idx*N_OUT +: N_OUT]<=dut_out. If dut_out != latched expected slice: mismatch_cnt<=mismatch_cnt+1, and first_fail_idx<=idx if this is the first mismatch. If idx==2**N_IN-1 go to FINISH; else idx<=idx+1, dut_in<=idx+1, cnt<=HOLD_CYCLES-1, go to SETTLE.
- FINISH (1 cycle): done=1; pass=(mismatch_cnt==0), valid from this cycle and held. Next state IDLE.
- Vectors are applied in ascending binary order 0..2**N_IN-1. Each is held HOLD_CYCLES+1 cycles. dut_in remains at the last vector after FINISH until the next start or reset.
- Latency: done is high in the cycle after edge number 2**N_IN*(HOLD_CYCLES+1), counting the start-accepting edge as 0. Defaults: 40.
- start while busy or in FINISH: ignored, no effect on sweep. start held continuously: a new sweep is accepted on the first IDLE cycle after FINISH.
- Changes to exp_table after start accept have no effect on the current sweep.
- The mismatch_cnt width holds a count of all 2**N_IN vectors without overflow.

Test Plan:
- Reset values: assert rst 2 cycles -> all outputs 0, busy=0; start pulse then rst at the next edge -> state IDLE, all outputs 0.
- Full matching sweep, defaults, bench model of ex1 driving exp_table -> dut_in steps 0..7, each held 5 cycles; done single pulse at edge 40; pass=1; mismatch_cnt=0; table_out==exp_table.
- Injected mismatches: exp_table with vector 5 and vector 6 slices inverted -> mismatch_cnt=2, first_fail_idx=5, pass=0, table_out equals true model outputs.
- start pulses during busy (at edges 3, 17, 39) and exp_table changed at edge 10 -> single sweep, done still at edge 40, comparison uses the exp_table latched at edge 0.
- Reset mid-run at vector 3 -> all outputs 0 on the next cycle; a fresh start restarts from dut_in=0 and completes normally with done at edge 40.
- HOLD_CYCLES=1, N_IN=2, N_OUT=1 -> vectors 0..3 held 2 cycles each, done at edge 8; start held high permanently -> back-to-back sweeps, next start accepted in the IDLE cycle following FINISH.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector of a small combinational
// datapath, waits a programmable settle time before sampling the outputs,
// packs the samples into a truth table and compares it with an expected table.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | results held; waiting for start
// SETTLE  | vector idx on dut_in; counting down HOLD_CYCLES settle cycles
// SAMPLE  | capture dut_out for vector idx; compare; advance or finish
// FINISH  | one-cycle done pulse; pass valid from here on
module truth_table_sweeper #(
  parameter int N_IN        = 3,
  parameter int N_OUT       = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [(2**N_IN)*N_OUT-1:0]  exp_table,
  output logic [N_IN-1:0]             dut_in,
  input  logic [N_OUT-1:0]            dut_out,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [(2**N_IN)*N_OUT-1:0]  table_out,
  output logic [N_IN:0]               mismatch_cnt,
  output logic [N_IN-1:0]             first_fail_idx
);

  localparam int TW = (2**N_IN) * N_OUT;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic [TW-1:0]   table_q, table_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   mm_q, mm_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  // Next-state and datapath update for the sweep sequencer; busy/done are
  // derived from the next state so they are registered alongside it.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    table_d  = table_q;
    idx_d    = idx_q;
    dut_in_d = dut_in_q;
    cnt_d    = cnt_q;
    mm_d     = mm_q;
    ff_d     = ff_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d    = exp_table;
          idx_d    = '0;
          dut_in_d = '0;
          cnt_d    = CNT_LOAD;
          table_d  = '0;
          mm_d     = '0;
          ff_d     = '0;
          pass_d   = 1'b0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        table_d[idx_q*N_OUT +: N_OUT] = dut_out;
        if (dut_out != exp_q[idx_q*N_OUT +: N_OUT]) begin
          mm_d = mm_q + 1'b1;
          // Vectors run in ascending order, so the first miss is the lowest.
          if (mm_q == '0) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == IDX_LAST) begin
          // pass must already be valid in the FINISH cycle, so it uses the
          // count including this final sample.
          pass_d  = (mm_d == '0);
          state_d = S_FINISH;
        end else begin
          idx_d    = idx_q + 1'b1;
          dut_in_d = idx_q + 1'b1;
          cnt_d    = CNT_LOAD;
          state_d  = S_SETTLE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_FINISH);
  end

  // State register with synchronous reset that discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      exp_q    <= '0;
      table_q  <= '0;
      idx_q    <= '0;
      dut_in_q <= '0;
      cnt_q    <= '0;
      mm_q     <= '0;
      ff_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      idx_q    <= idx_d;
      dut_in_q <= dut_in_d;
      cnt_q    <= cnt_d;
      mm_q     <= mm_d;
      ff_q     <= ff_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign table_out      = table_q;
  assign mismatch_cnt   = mm_q;
  assign first_fail_idx = ff_q;

endmodule
